adc0808_responder: RTL and testbench
====================================

# adc0808_responder

Synthesizable model of the ADC0808 converter side of the ADC control handshake: it responds to ALE/START/OE from an ADC controller, runs an 8-step successive-approximation conversion on a selected digital "analog" channel value, and signals completion on EOC. It substitutes for the physical converter on the Pmod header in loopback builds and in simulation, so the controller and the 7-segment path can be exercised without hardware.

## Interface
Parameters:
- `CLK_DIV`, 2000: clk cycles per converter clock tick (100 MHz → 50 kHz).
- `CONV_TICKS`, 64: converter ticks per conversion; must be a multiple of 8.
- `EOC_DELAY_TICKS`, 2: ticks from START rising until EOC falls.

Ports:
- `clk` input 1: system clock (CLK100MHZ domain).
- `reset` input 1: one clock; reset is synchronous and active-high.
- `ale` input 1: address latch enable.
- `start` input 1: conversion start.
- `oe` input 1: output enable.
- `addr` input 3: channel select, latched on ALE rising.
- `ch_values` input 64: channel i value is `ch_values[8*i +: 8]`.
- `eoc` output 1: end of conversion.
- `data_out` output 8: result when `oe`=1, else 0.
- `data_oe` output 1: tri-state enable for the top-level data pins; equals `oe`.

## Operation
- All inputs are synchronous to `clk`. Edges are detected against the previous-cycle registered value (`x & ~x_q` for rising, `~x & x_q` for falling).
- ALE rising: `addr_lat <= addr` in any state.
- States:
  - IDLE: waiting for START.
  - ARMED: START high; SAR cleared; EOC-delay counter running.
  - CONVERT: 8-bit SAR in progress.
  - DONE: result valid.
- START rising, from any state: go to ARMED, clear `sar`, restart the EOC-delay tick count. An in-progress conversion is aborted and `result` is unchanged.
- In ARMED, `eoc <= 0` once `EOC_DELAY_TICKS` ticks have elapsed.
- START falling while in ARMED:
  - `sample <= ch_values[addr_lat]`, `eoc <= 0` immediately, go to CONVERT.
  - Tick divider cleared, bit index = 7.
- CONVERT, every `CONV_TICKS/8` ticks:
  - `trial = sar | (1<<bit)`; `sar <= (trial <= sample) ? trial : sar`; `bit` decrements.
  - After bit 0 is decided: `result <= final sar`, `eoc <= 1`, go to DONE.
  - `result` always equals `sample`, all arithmetic is unsigned 8-bit, and `trial` never exceeds 0xFF.
- DONE behaves as IDLE; `eoc` stays 1 until the next START rising.
- `data_out = oe ? result : 8'h00` (combinational). A read during a conversion returns the previous result.
- ALE and START rising in the same cycle: the address is latched that cycle. The channel sample is taken later, at START falling, so it uses the new address.
- ALE rising during CONVERT updates `addr_lat` only and does not affect `sample`.

## Timing
- Reset values: state IDLE, `eoc`=1, `result`=0, `sar`=0, `addr_lat`=0, `sample`=0, divider=0. Outputs `data_out`=0 and `data_oe`=0 while `oe`=0.
- Ticks:
  - Free-running divider, one `tick` per `CLK_DIV` cycles.
  - The divider restarts at CONVERT entry, so the k-th tick falls at edge T + k·`CLK_DIV`, where T is the edge that samples START falling.
- EOC fall latency:
  - ≤ `EOC_DELAY_TICKS`·`CLK_DIV` + `CLK_DIV` cycles after START rising.
  - 1 cycle after START falling, whichever comes first.
- Conversion latency: `eoc` and `result` update at edge T + `CONV_TICKS`·`CLK_DIV` and are visible on the following cycle.
- `data_oe` and `data_out` follow `oe` with zero cycles of latency.
- Reset mid-operation: all reset values apply on the next edge, and a pending conversion is discarded.

## Structure
- Package `adc0808_pkg`:
  - State enum (IDLE, ARMED, CONVERT, DONE).
  - Default constants `ADC_CLK_DIV`, `ADC_CONV_TICKS`, `ADC_EOC_DELAY_TICKS`.
  - `ADC_DATA_W`=8 and `ADC_N_CH`=8.
- One sub-module, `adc_tick_gen`: a divider producing a 1-cycle `tick` every `CLK_DIV` cycles, with a synchronous `clear` input.
- FSM, SAR datapath and edge detectors live in `adc0808_responder`. The top level wires `data_oe`/`data_out` to the inout pins.

## Test plan
All scenarios use `CLK_DIV`=4, `CONV_TICKS`=64, `EOC_DELAY_TICKS`=2.
- Reset held 3 cycles → `eoc`=1, `data_oe`=0, `data_out`=0x00. Raising `oe` → `data_out`=0x00.
- Channel 3 = 0xA5; ALE pulse with `addr`=3; START high 2 cycles then low → `eoc` falls 1 cycle after START falls and rises exactly 256 cycles after the edge that sampled START low. `oe`=1 → `data_out`=0xA5.
- Conversion on channel 0 = 0x00, then channel 7 = 0xFF → results 0x00 and 0xFF. SAR trace for 0xFF has every bit kept.
- After a completed 0xA5 conversion, set channel 3 = 0x3C and start a new conversion. Hold `oe`=1 mid-conversion → `data_out`=0xA5. After `eoc` rises → `data_out`=0x3C.
- START re-pulsed at tick 20 of a conversion, with the channel changed to 0x81 → no `eoc` rise at the original deadline. `eoc` rises 256 cycles after the second START falls. Result = 0x81.
- `reset` asserted at tick 30 of a conversion → next cycle `eoc`=1, `result`=0x00, state IDLE. A subsequent START falling with no new ALE converts channel 0.

Source files
------------

// File: rtl/adc0808_pkg.sv
// Shared types and constants for the ADC0808 converter responder.
package adc0808_pkg;

    localparam int unsigned ADC_CLK_DIV         = 2000;
    localparam int unsigned ADC_CONV_TICKS      = 64;
    localparam int unsigned ADC_EOC_DELAY_TICKS = 2;
    localparam int unsigned ADC_DATA_W          = 8;
    localparam int unsigned ADC_N_CH            = 8;
    localparam int unsigned ADC_ADDR_W          = 3;
    localparam int unsigned ADC_BIT_W           = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } adc_state_e;

    // One successive-approximation step: keep the trial bit if it does not overshoot.
    function automatic logic [ADC_DATA_W-1:0] sar_decide(
        input logic [ADC_DATA_W-1:0] sar,
        input logic [ADC_BIT_W-1:0]  bit_idx,
        input logic [ADC_DATA_W-1:0] sample
    );
        logic [ADC_DATA_W-1:0] trial;
        trial = sar | (ADC_DATA_W'(1) << bit_idx);
        return (trial <= sample) ? trial : sar;
    endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Converter clock divider: one-cycle tick every CLK_DIV clk cycles.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the divider; the first tick lands CLK_DIV edges later
//   tick       : registered one-cycle pulse
module adc_tick_gen #(
    parameter int unsigned CLK_DIV = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // tick is raised one edge early so the consumer sees it on the CLK_DIV-th edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CNT_W'(CLK_DIV - 2));
            if (cnt == CNT_W'(CLK_DIV - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc0808_responder.sv
// ADC0808 converter-side model: answers ALE/START/OE, performs an 8-step SAR
// conversion of a digital channel value and reports completion on EOC.
//   clk, reset : system clock, synchronous active-high reset
//   ale        : address latch enable (addr latched on rising edge)
//   start      : conversion start (arm on rising, sample on falling)
//   oe         : output enable
//   addr       : channel select
//   ch_values  : eight 8-bit channel values, channel i at [8*i +: 8]
//   eoc        : end of conversion (registered)
//   data_out   : result when oe=1, else 0 (combinational)
//   data_oe    : tri-state enable for the data pins, equals oe
module adc0808_responder
    import adc0808_pkg::*;
#(
    parameter int unsigned CLK_DIV         = ADC_CLK_DIV,
    parameter int unsigned CONV_TICKS      = ADC_CONV_TICKS,
    parameter int unsigned EOC_DELAY_TICKS = ADC_EOC_DELAY_TICKS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           ale,
    input  logic                           start,
    input  logic                           oe,
    input  logic [ADC_ADDR_W-1:0]          addr,
    input  logic [ADC_N_CH*ADC_DATA_W-1:0] ch_values,
    output logic                           eoc,
    output logic [ADC_DATA_W-1:0]          data_out,
    output logic                           data_oe
);

    localparam int unsigned STEP_TICKS = CONV_TICKS / 8;
    localparam int unsigned STEP_W     = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int unsigned EOC_CW     = (EOC_DELAY_TICKS > 0) ? $clog2(EOC_DELAY_TICKS + 1) : 1;

    adc_state_e              state, state_d;
    logic                    ale_q, start_q;
    logic [ADC_ADDR_W-1:0]   addr_lat, addr_lat_d;
    logic [ADC_DATA_W-1:0]   sample, sample_d;
    logic [ADC_DATA_W-1:0]   sar, sar_d;
    logic [ADC_DATA_W-1:0]   result, result_d;
    logic                    eoc_d;
    logic [ADC_BIT_W-1:0]    bit_idx, bit_d;
    logic [STEP_W-1:0]       step_cnt, step_d;
    logic [EOC_CW-1:0]       eoc_cnt, eoc_cnt_d;
    logic                    tick;
    logic                    div_clear_c;
    logic                    ale_rise_c, start_rise_c, start_fall_c;
    logic [ADC_DATA_W-1:0]   ch_arr [ADC_N_CH];

    // Unpack the flat channel bus so the latched address can index it directly.
    for (genvar i = 0; i < int'(ADC_N_CH); i++) begin : g_ch
        assign ch_arr[i] = ch_values[ADC_DATA_W*i +: ADC_DATA_W];
    end

    assign ale_rise_c   = ale & ~ale_q;
    assign start_rise_c = start & ~start_q;
    assign start_fall_c = ~start & start_q;

    assign data_oe  = oe;
    assign data_out = oe ? result : '0;

    adc_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (div_clear_c),
        .tick  (tick)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ale_q    <= 1'b0;
            start_q  <= 1'b0;
            addr_lat <= '0;
            sample   <= '0;
            sar      <= '0;
            result   <= '0;
            eoc      <= 1'b1;
            bit_idx  <= '0;
            step_cnt <= '0;
            eoc_cnt  <= '0;
        end else begin
            state    <= state_d;
            ale_q    <= ale;
            start_q  <= start;
            addr_lat <= addr_lat_d;
            sample   <= sample_d;
            sar      <= sar_d;
            result   <= result_d;
            eoc      <= eoc_d;
            bit_idx  <= bit_d;
            step_cnt <= step_d;
            eoc_cnt  <= eoc_cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state;
        addr_lat_d  = addr_lat;
        sample_d    = sample;
        sar_d       = sar;
        result_d    = result;
        eoc_d       = eoc;
        bit_d       = bit_idx;
        step_d      = step_cnt;
        eoc_cnt_d   = eoc_cnt;
        div_clear_c = 1'b0;

        if (ale_rise_c) begin
            addr_lat_d = addr;
        end

        // START rising wins over everything and aborts a running conversion.
        if (start_rise_c) begin
            state_d   = ST_ARMED;
            sar_d     = '0;
            eoc_cnt_d = '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (start_fall_c) begin
                        sample_d    = ch_arr[addr_lat];
                        eoc_d       = 1'b0;
                        state_d     = ST_CONVERT;
                        div_clear_c = 1'b1;
                        step_d      = '0;
                        bit_d       = ADC_BIT_W'(ADC_DATA_W - 1);
                    end else if (eoc_cnt == EOC_CW'(EOC_DELAY_TICKS)) begin
                        eoc_d = 1'b0;
                    end else if (tick) begin
                        eoc_cnt_d = eoc_cnt + EOC_CW'(1);
                    end
                end
                ST_CONVERT: begin
                    if (tick) begin
                        if (step_cnt == STEP_W'(STEP_TICKS - 1)) begin
                            step_d = '0;
                            sar_d  = sar_decide(sar, bit_idx, sample);
                            if (bit_idx == '0) begin
                                result_d = sar_d;
                                eoc_d    = 1'b1;
                                state_d  = ST_DONE;
                            end else begin
                                bit_d = bit_idx - ADC_BIT_W'(1);
                            end
                        end else begin
                            step_d = step_cnt + STEP_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc0808_responder.sv
module tb_adc0808_responder;
    import adc0808_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ale;
    logic        start;
    logic        oe;
    logic [2:0]  addr;
    logic [63:0] ch_values;
    logic        eoc;
    logic [7:0]  data_out;
    logic        data_oe;

    int n_checks = 0;
    int n_fail   = 0;

    adc0808_responder #(
        .CLK_DIV         (4),
        .CONV_TICKS      (64),
        .EOC_DELAY_TICKS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ale       (ale),
        .start     (start),
        .oe        (oe),
        .addr      (addr),
        .ch_values (ch_values),
        .eoc       (eoc),
        .data_out  (data_out),
        .data_oe   (data_oe)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] v);
        ch_values[8*ch +: 8] = v;
    endtask

    task automatic pulse_ale(input logic [2:0] a);
        addr = a;
        ale  = 1'b1;
        step_clk();
        ale  = 1'b0;
        step_clk();
    endtask

    // Leaves the bench #1 after the edge that sampled START low.
    task automatic start_pulse();
        start = 1'b1;
        step_clk();
        step_clk();
        start = 1'b0;
        step_clk();
    endtask

    // Cycles from the current point until eoc is seen high, bounded.
    task automatic cycles_to_eoc(output int cnt);
        cnt = 0;
        while (!eoc && cnt < 300) begin
            step_clk();
            cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ale = 1'b0; start = 1'b0; oe = 1'b0; addr = 3'd0; ch_values = '0;
        repeat (3) step_clk();
        reset = 1'b0;
        step_clk();
        n_checks++;
        if (eoc !== 1'b1) begin n_fail++; $display("FAIL reset_eoc got %b want 1", eoc); end
        n_checks++;
        if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe got %b want 0", data_oe); end
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out got %h want 00", data_out); end
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_oe !== 1'b1) begin n_fail++; $display("FAIL reset_oe_data_oe got %b want 1", data_oe); end
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_oe_data_out got %h want 00", data_out); end
        oe = 1'b0;
        #1;
        n_checks++;
        if (data_oe !== 1'b0) begin n_fail++; $display("FAIL oe_drop_data_oe got %b want 0", data_oe); end
    endtask

    task automatic test_basic();
        int cnt;
        set_ch(3, 8'hA5);
        pulse_ale(3'd3);
        start_pulse();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL basic_eoc_fall got %b want 0", eoc); end
        cycles_to_eoc(cnt);
        n_checks++;
        if (cnt !== 256) begin n_fail++; $display("FAIL basic_latency got %0d want 256", cnt); end
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL basic_result got %h want a5", data_out); end
        oe = 1'b0;
    endtask

    task automatic test_extremes();
        int cnt;
        logic [7:0] exp_sar;
        set_ch(0, 8'h00);
        pulse_ale(3'd0);
        start_pulse();
        cycles_to_eoc(cnt);
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL ch0_result got %h want 00", data_out); end
        oe = 1'b0;

        // Each bit decision lands every 32 cycles; for 0xFF every trial bit is kept.
        set_ch(7, 8'hFF);
        pulse_ale(3'd7);
        start_pulse();
        for (int j = 1; j <= 8; j++) begin
            repeat (32) step_clk();
            exp_sar = 8'(8'hFF << (8 - j));
            n_checks++;
            if (dut.sar !== exp_sar) begin
                n_fail++; $display("FAIL sar_trace_%0d got %h want %h", j, dut.sar, exp_sar);
            end
        end
        n_checks++;
        if (eoc !== 1'b1) begin n_fail++; $display("FAIL ch7_eoc got %b want 1", eoc); end
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'hFF) begin n_fail++; $display("FAIL ch7_result got %h want ff", data_out); end
        oe = 1'b0;
    endtask

    task automatic test_read_during_conv();
        int cnt;
        set_ch(3, 8'hA5);
        pulse_ale(3'd3);
        start_pulse();
        cycles_to_eoc(cnt);
        set_ch(3, 8'h3C);
        start_pulse();
        oe = 1'b1;
        repeat (100) step_clk();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL midconv_eoc got %b want 0", eoc); end
        n_checks++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL midconv_data got %h want a5", data_out); end
        cycles_to_eoc(cnt);
        n_checks++;
        if (data_out !== 8'h3C) begin n_fail++; $display("FAIL newconv_data got %h want 3c", data_out); end
        oe = 1'b0;
    endtask

    task automatic test_restart();
        int cnt;
        set_ch(3, 8'h5A);
        pulse_ale(3'd3);
        start_pulse();
        repeat (80) step_clk();
        set_ch(3, 8'h81);
        start_pulse();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL restart_eoc_low got %b want 0", eoc); end
        cycles_to_eoc(cnt);
        n_checks++;
        if (cnt !== 256) begin n_fail++; $display("FAIL restart_latency got %0d want 256", cnt); end
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'h81) begin n_fail++; $display("FAIL restart_result got %h want 81", data_out); end
        oe = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cnt;
        set_ch(5, 8'h77);
        set_ch(0, 8'h42);
        pulse_ale(3'd5);
        start_pulse();
        repeat (120) step_clk();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        n_checks++;
        if (eoc !== 1'b1) begin n_fail++; $display("FAIL midreset_eoc got %b want 1", eoc); end
        n_checks++;
        if (dut.state !== ST_IDLE) begin n_fail++; $display("FAIL midreset_state got %0d want 0", dut.state); end
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL midreset_result got %h want 00", data_out); end
        oe = 1'b0;
        step_clk();
        // No new ALE: the address latch was reset to channel 0.
        start_pulse();
        cycles_to_eoc(cnt);
        n_checks++;
        if (cnt !== 256) begin n_fail++; $display("FAIL postreset_latency got %0d want 256", cnt); end
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'h42) begin n_fail++; $display("FAIL postreset_result got %h want 42", data_out); end
        oe = 1'b0;
    endtask

    task automatic test_eoc_delay();
        int cnt;
        set_ch(0, 8'h9C);
        start = 1'b1;
        step_clk();
        n_checks++;
        if (eoc !== 1'b1) begin n_fail++; $display("FAIL armed_eoc_early got %b want 1", eoc); end
        repeat (11) step_clk();
        n_checks++;
        if (eoc !== 1'b0) begin n_fail++; $display("FAIL armed_eoc_delay got %b want 0", eoc); end
        start = 1'b0;
        step_clk();
        cycles_to_eoc(cnt);
        n_checks++;
        if (cnt !== 256) begin n_fail++; $display("FAIL long_start_latency got %0d want 256", cnt); end
        oe = 1'b1;
        #1;
        n_checks++;
        if (data_out !== 8'h9C) begin n_fail++; $display("FAIL long_start_result got %h want 9c", data_out); end
        oe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_read_during_conv();
        test_restart();
        test_reset_mid();
        test_eoc_delay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
